// File: rtl/sync_decoder_n.sv
// rtl/sync_decoder_n.sv - registered N-to-2**N decoder with direct and scanning index modes
module sync_decoder_n #(
    parameter int N          = 3,
    parameter bit ACTIVE_LOW = 1'b0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            en,
    input  logic            start,
    input  logic            stop,
    input  logic [1:0]      mode,
    input  logic [N-1:0]    sel,
    output logic [2**N-1:0] y,
    output logic [N-1:0]    idx,
    output logic            out_valid,
    output logic            wrap
);
    localparam int W = 2 ** N;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_DIRECT    = 2'd1;
    localparam logic [1:0] ST_SCAN_UP   = 2'd2;
    localparam logic [1:0] ST_SCAN_DOWN = 2'd3;

    localparam logic [N-1:0] IDX_MAX = {N{1'b1}};
    localparam logic [N-1:0] IDX_ONE = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]   state_q, state_d;
    logic [N-1:0] idx_q, idx_d;
    logic [W-1:0] y_q, y_d;
    logic         valid_q, valid_d;
    logic         wrap_q, wrap_d;
    logic [1:0]   mode_state;
    logic [W-1:0] dec;

    always_comb begin
        case (mode)
            2'b01:   mode_state = ST_SCAN_UP;
            2'b10:   mode_state = ST_SCAN_DOWN;
            default: mode_state = ST_DIRECT;
        endcase
    end

    // stop beats start; stepping only happens on quiet, enabled cycles
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        wrap_d  = 1'b0;
        if (stop) begin
            state_d = ST_IDLE;
        end else if (start) begin
            state_d = mode_state;
            idx_d   = sel;
        end else if (en) begin
            if (state_q == ST_SCAN_UP) begin
                idx_d  = idx_q + IDX_ONE;
                wrap_d = (idx_q == IDX_MAX);
            end else if (state_q == ST_SCAN_DOWN) begin
                idx_d  = idx_q - IDX_ONE;
                wrap_d = (idx_q == '0);
            end
        end
    end

    always_comb begin
        valid_d     = (state_d != ST_IDLE) && en;
        dec         = '0;
        dec[idx_d]  = valid_d;
        y_d         = ACTIVE_LOW ? ~dec : dec;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            valid_q <= 1'b0;
            wrap_q  <= 1'b0;
            y_q     <= ACTIVE_LOW ? {W{1'b1}} : {W{1'b0}};
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            valid_q <= valid_d;
            wrap_q  <= wrap_d;
            y_q     <= y_d;
        end
    end

    assign y         = y_q;
    assign idx       = idx_q;
    assign out_valid = valid_q;
    assign wrap      = wrap_q;
endmodule

// File: tb/tb_sync_decoder_n.sv
// tb/tb_sync_decoder_n.sv - self-checking bench for sync_decoder_n, both output polarities
module tb_sync_decoder_n;
    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       en = 1'b0;
    logic       start = 1'b0;
    logic       stop = 1'b0;
    logic [1:0] mode = 2'd0;
    logic [2:0] sel = 3'd0;
    logic [7:0] y, y_al;
    logic [2:0] idx, idx_al;
    logic       out_valid, valid_al, wrap, wrap_al;

    int checks = 0;
    int failures = 0;

    // reference: 0 idle, 1 direct, 2 scan up, 3 scan down
    int       m_st = 0;
    int       m_idx = 0;
    bit       m_valid = 0;
    bit       m_wrap = 0;
    bit [7:0] m_y = 8'h00;

    sync_decoder_n #(.N(3), .ACTIVE_LOW(1'b0)) dut (
        .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .mode(mode), .sel(sel),
        .y(y), .idx(idx), .out_valid(out_valid), .wrap(wrap)
    );

    sync_decoder_n #(.N(3), .ACTIVE_LOW(1'b1)) dut_al (
        .clk(clk), .rst(rst), .en(en), .start(start), .stop(stop), .mode(mode), .sel(sel),
        .y(y_al), .idx(idx_al), .out_valid(valid_al), .wrap(wrap_al)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_step();
        m_wrap = 0;
        if (rst) begin
            m_st  = 0;
            m_idx = 0;
        end else if (stop) begin
            m_st = 0;
        end else if (start) begin
            m_st  = (mode == 2'd1) ? 2 : (mode == 2'd2) ? 3 : 1;
            m_idx = sel;
        end else if (en && m_st == 2) begin
            m_wrap = (m_idx == 7);
            m_idx  = (m_idx + 1) % 8;
        end else if (en && m_st == 3) begin
            m_wrap = (m_idx == 0);
            m_idx  = (m_idx + 7) % 8;
        end
        m_valid = !rst && (m_st != 0) && en;
        m_y     = m_valid ? 8'(1 << m_idx) : 8'h00;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        rst   = 1'b0;
        start = 1'b0;
        stop  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b1; start = 1'b1; mode = 2'd1; sel = 3'd4;
        tick();
        checks++; if (idx !== 3'd0) begin failures++; $display("FAIL reset_idx got=%0d exp=0", idx); end
        checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
        checks++; if (wrap !== 1'b0) begin failures++; $display("FAIL reset_wrap got=%b exp=0", wrap); end
        checks++; if (y !== 8'h00) begin failures++; $display("FAIL reset_y got=%b exp=00000000", y); end
        checks++; if (y_al !== 8'hFF) begin failures++; $display("FAIL reset_y_al got=%b exp=11111111", y_al); end
    endtask

    task automatic test_direct();
        en = 1'b1; start = 1'b1; mode = 2'd0; sel = 3'd5;
        tick();
        sel = 3'd1;
        for (int i = 0; i < 3; i++) begin
            checks++; if (y !== 8'b0010_0000) begin failures++; $display("FAIL direct_y cyc=%0d got=%b exp=00100000", i, y); end
            checks++; if (idx !== 3'd5 || out_valid !== 1'b1) begin failures++; $display("FAIL direct_idx_valid cyc=%0d got=%0d/%b exp=5/1", i, idx, out_valid); end
            tick();
        end
        stop = 1'b1;
        tick();
        checks++; if (y !== 8'h00 || out_valid !== 1'b0) begin failures++; $display("FAIL direct_stop got=%b/%b exp=00000000/0", y, out_valid); end
    endtask

    task automatic test_active_low();
        en = 1'b1; start = 1'b1; mode = 2'd0; sel = 3'd2;
        tick();
        checks++; if (y_al !== 8'b1111_1011) begin failures++; $display("FAIL al_direct_y got=%b exp=11111011", y_al); end
        en = 1'b0;
        tick();
        checks++; if (y_al !== 8'hFF || valid_al !== 1'b0) begin failures++; $display("FAIL al_disabled got=%b/%b exp=11111111/0", y_al, valid_al); end
        en = 1'b1; stop = 1'b1;
        tick();
    endtask

    task automatic test_scan_up();
        int exp_idx[4] = '{6, 7, 0, 1};
        bit exp_wrap[4] = '{0, 0, 1, 0};
        en = 1'b1; start = 1'b1; mode = 2'd1; sel = 3'd6;
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (idx !== 3'(exp_idx[i])) begin failures++; $display("FAIL scan_up_idx step=%0d got=%0d exp=%0d", i, idx, exp_idx[i]); end
            checks++; if (wrap !== exp_wrap[i]) begin failures++; $display("FAIL scan_up_wrap step=%0d got=%b exp=%b", i, wrap, exp_wrap[i]); end
        end
        stop = 1'b1;
        tick();
    endtask

    task automatic test_scan_down_pause();
        int exp_idx[3] = '{1, 0, 7};
        bit exp_wrap[3] = '{0, 0, 1};
        en = 1'b1; start = 1'b1; mode = 2'd2; sel = 3'd1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (idx !== 3'(exp_idx[i]) || wrap !== exp_wrap[i]) begin failures++; $display("FAIL scan_down step=%0d got=%0d/%b exp=%0d/%b", i, idx, wrap, exp_idx[i], exp_wrap[i]); end
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (y !== 8'h00 || out_valid !== 1'b0 || idx !== 3'd7 || wrap !== 1'b0) begin failures++; $display("FAIL scan_pause cyc=%0d got=y%b v%b i%0d w%b exp=y00000000 v0 i7 w0", i, y, out_valid, idx, wrap); end
        end
        en = 1'b1;
        tick();
        checks++; if (idx !== 3'd6 || y !== 8'b0100_0000 || out_valid !== 1'b1) begin failures++; $display("FAIL scan_resume got=%0d/%b/%b exp=6/01000000/1", idx, y, out_valid); end
        stop = 1'b1;
        tick();
    endtask

    task automatic test_start_stop();
        en = 1'b1; start = 1'b1; mode = 2'd1; sel = 3'd7;
        tick();
        start = 1'b1; mode = 2'd1; sel = 3'd0;
        tick();
        checks++; if (idx !== 3'd0 || wrap !== 1'b0) begin failures++; $display("FAIL reload_no_wrap got=%0d/%b exp=0/0", idx, wrap); end
        tick();
        start = 1'b1; stop = 1'b1; sel = 3'd5;
        tick();
        checks++; if (out_valid !== 1'b0 || idx !== 3'd1 || y !== 8'h00) begin failures++; $display("FAIL start_stop got=v%b i%0d y%b exp=v0 i1 y00000000", out_valid, idx, y); end
        tick();
        checks++; if (out_valid !== 1'b0 || idx !== 3'd1) begin failures++; $display("FAIL idle_hold got=v%b i%0d exp=v0 i1", out_valid, idx); end
    endtask

    task automatic test_reset_mid_scan();
        en = 1'b1; start = 1'b1; mode = 2'd1; sel = 3'd7;
        tick();
        rst = 1'b1;
        tick();
        checks++; if (idx !== 3'd0 || wrap !== 1'b0 || out_valid !== 1'b0) begin failures++; $display("FAIL reset_mid_scan got=i%0d w%b v%b exp=i0 w0 v0", idx, wrap, out_valid); end
        tick();
        checks++; if (idx !== 3'd0 || out_valid !== 1'b0) begin failures++; $display("FAIL reset_idle got=i%0d v%b exp=i0 v0", idx, out_valid); end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 39) == 0);
            start = ($urandom_range(0, 5) == 0);
            stop  = ($urandom_range(0, 9) == 0);
            en    = ($urandom_range(0, 4) != 0);
            mode  = 2'($urandom_range(0, 3));
            sel   = 3'($urandom_range(0, 7));
            tick();
            checks++; if (idx !== 3'(m_idx)) begin failures++; $display("FAIL rand_idx cyc=%0d got=%0d exp=%0d", i, idx, m_idx); end
            checks++; if (out_valid !== m_valid) begin failures++; $display("FAIL rand_valid cyc=%0d got=%b exp=%b", i, out_valid, m_valid); end
            checks++; if (wrap !== m_wrap) begin failures++; $display("FAIL rand_wrap cyc=%0d got=%b exp=%b", i, wrap, m_wrap); end
            checks++; if (y !== m_y) begin failures++; $display("FAIL rand_y cyc=%0d got=%b exp=%b", i, y, m_y); end
            checks++; if (y_al !== ~m_y || wrap_al !== m_wrap || idx_al !== 3'(m_idx)) begin failures++; $display("FAIL rand_al cyc=%0d got=%b exp=%b", i, y_al, ~m_y); end
        end
    endtask

    initial begin
        #2;
        test_reset();
        test_direct();
        test_active_low();
        test_scan_up();
        test_scan_down_pause();
        test_start_stop();
        test_reset_mid_scan();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/sync_decoder_n.md
SYNC_DECODER_N -- requirements
Module: sync_decoder_n

Interface
REQ-001 Parameter N, default 3, meaning select width; output width is 2**N; legal range 1..6.
REQ-002 Parameter ACTIVE_LOW, default 0, meaning output polarity (0: selected line 1, others 0; 1: selected line 0, others 1).
REQ-003 Single clock domain; reset is synchronous and active-high.
REQ-004 clk  input  1  clock, all state updates on rising edge.
REQ-005 rst  input  1  synchronous active-high reset.
REQ-006 en  input  1  enable; 0 freezes index and forces outputs inactive.
REQ-007 start  input  1  single-cycle request: load sel and mode.
REQ-008 stop  input  1  single-cycle request: return to IDLE.
REQ-009 mode  input  2  00 DIRECT, 01 SCAN_UP, 10 SCAN_DOWN, 11 reserved (treated as DIRECT).
REQ-010 sel  input  N  binary select / scan start index.
REQ-011 y  output  2**N  registered one-hot decode of idx, polarity per ACTIVE_LOW.
REQ-012 idx  output  N  registered current index.
REQ-013 out_valid  output  1  y holds a valid decode this cycle.
REQ-014 wrap  output  1  one-cycle pulse when a scan wraps.

Function
REQ-015 FSM states IDLE, DIRECT, SCAN_UP, SCAN_DOWN; state is registered.
REQ-016 IDLE: start=1 and stop=0 -> state per mode, idx <= sel; otherwise stay in IDLE, idx unchanged.
REQ-017 Any non-IDLE state: stop=1 -> IDLE (stop wins over a simultaneous start); start=1 alone -> reload idx <= sel and move to the state given by mode.
REQ-018 DIRECT, no start/stop: idx holds.
REQ-019 SCAN_UP, en=1, no start/stop: idx <= idx+1 modulo 2**N; 2**N-1 -> 0 asserts wrap in the same registered cycle that idx becomes 0.
REQ-020 SCAN_DOWN, en=1, no start/stop: idx <= idx-1 modulo 2**N; 0 -> 2**N-1 asserts wrap in the same registered cycle that idx becomes 2**N-1.
REQ-021 A start/stop cycle never asserts wrap, even if the loaded sel equals the wrap value.
REQ-022 en=0: idx and state hold in every state, and scan stepping pauses; start/stop are still honoured.
REQ-023 y and out_valid are registered from the next-state and next-idx values of the same edge, so a start at edge k shows the decoded sel after edge k.
REQ-024 out_valid = 1 iff the next state is not IDLE and en=1 at that edge.
REQ-025 When out_valid=0, y is all-inactive (all 0 if ACTIVE_LOW=0, all 1 if ACTIVE_LOW=1).
REQ-026 When out_valid=1, exactly one bit of y is active, namely bit idx.
REQ-027 wrap is high for exactly one cycle per wrap event; it is 0 whenever en=0 or the state is IDLE or DIRECT.
REQ-028 No combinational path from any input to any output.

Reset
REQ-029 rst=1 at a clock edge: state IDLE, idx=0, out_valid=0, wrap=0, y all-inactive; this overrides start, stop and en in the same cycle.
REQ-030 Reset asserted mid-scan takes effect at the next edge; no wrap pulse is generated by the reset.

Verification
REQ-031 N=3, ACTIVE_LOW=0, en=1, start with mode=00, sel=5 -> next cycle y=00100000, idx=5, out_valid=1; y holds until stop, then y=00000000, out_valid=0.
REQ-032 N=3, en=1, start with mode=01, sel=6 -> idx 6,7,0,1 over successive cycles; wrap=1 only in the idx=0 cycle.
REQ-033 N=3, mode=10, sel=1 -> idx 1,0,7; wrap=1 only in the idx=7 cycle. Drop en for 2 cycles mid-scan -> y=00000000, out_valid=0, idx frozen; scan resumes from the frozen idx.
REQ-034 ACTIVE_LOW=1, N=3, DIRECT sel=2 -> y=11111011; with en=0 -> y=11111111.
REQ-035 Simultaneous start and stop while in SCAN_UP -> IDLE next cycle, out_valid=0, no reload.
REQ-036 rst pulsed during SCAN_UP at idx=7 -> idx=0, wrap=0, out_valid=0, state IDLE after the edge.
